fmm_row_nnz_scan: RTL and testbench

FMM_ROW_NNZ_SCAN -- requirements
Module: fmm_row_nnz_scan

---
 rtl/fmm_row_nnz_scan.sv | 143 ++++++++++++++
 tb/tb_fmm_row_nnz_scan.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fmm_row_nnz_scan.sv
// rtl/fmm_row_nnz_scan.sv - scans one M_e row and reports nonzero count and first nonzero column
// Optional sign tallies (pos_count/neg_count) are built only when FMM_ROW_SCAN_SIGN_EN is defined.
module fmm_row_nnz_scan (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        ap_start,
  input  logic [16:0] row_base,
  input  logic [31:0] ncols,
  output logic [16:0] M_e_address0,
  output logic        M_e_ce0,
  input  logic [31:0] M_e_q0,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [31:0] nnz_count,
  output logic [30:0] first_nz_col,
  output logic        row_is_zero,
  output logic [31:0] pos_count,
  output logic [31:0] neg_count
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [30:0] NO_COL = 31'h7FFF_FFFF;

  state_t      state, state_nxt;
  logic [16:0] base_r;
  logic [30:0] last_col;
  logic [30:0] col;
  logic [30:0] rd_col;
  logic        rd_valid;
  logic        empty_r;
  logic        scan_start;
  logic        nonempty;
  logic        word_nz;

  assign nonempty   = !ncols[31] && (ncols != 32'd0);
  assign scan_start = (state == IDLE) && ap_start;
  // rd_valid/rd_col track the read issued last cycle, whose data is on M_e_q0 now
  assign word_nz    = rd_valid && (M_e_q0 != 32'd0);

  assign ap_idle     = (state == IDLE) && !ap_start;
  assign row_is_zero = (nnz_count == 32'd0);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    M_e_ce0      = 1'b0;
    M_e_address0 = 17'd0;
    ap_done      = 1'b0;
    ap_ready     = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) begin
          state_nxt = nonempty ? READ : DONE;
        end
      end
      READ: begin
        M_e_ce0      = 1'b1;
        M_e_address0 = base_r + col[16:0];
        if (col == last_col) begin
          ap_ready  = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        ap_done   = 1'b1;
        ap_ready  = empty_r;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      base_r       <= 17'd0;
      last_col     <= 31'd0;
      col          <= 31'd0;
      rd_col       <= 31'd0;
      rd_valid     <= 1'b0;
      empty_r      <= 1'b0;
      nnz_count    <= 32'd0;
      first_nz_col <= NO_COL;
    end else begin
      rd_valid <= M_e_ce0;
      rd_col   <= col;
      if (scan_start) begin
        base_r       <= row_base;
        last_col     <= ncols[30:0] - 31'd1;
        col          <= 31'd0;
        empty_r      <= !nonempty;
        nnz_count    <= 32'd0;
        first_nz_col <= NO_COL;
      end else begin
        if (M_e_ce0) begin
          col <= col + 31'd1;
        end
        // NO_COL can never be a real column, so it doubles as "nothing found yet"
        if (word_nz) begin
          nnz_count <= nnz_count + 32'd1;
          if (first_nz_col == NO_COL) begin
            first_nz_col <= rd_col;
          end
        end
      end
    end
  end

`ifdef FMM_ROW_SCAN_SIGN_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pos_count <= 32'd0;
      neg_count <= 32'd0;
    end else if (scan_start) begin
      pos_count <= 32'd0;
      neg_count <= 32'd0;
    end else if (word_nz) begin
      if (M_e_q0[31]) begin
        neg_count <= neg_count + 32'd1;
      end else begin
        pos_count <= pos_count + 32'd1;
      end
    end
  end
`else
  assign pos_count = 32'd0;
  assign neg_count = 32'd0;
`endif

endmodule

// File: tb/tb_fmm_row_nnz_scan.sv
// tb/tb_fmm_row_nnz_scan.sv - scoreboard bench for fmm_row_nnz_scan
// Expected results are queued by the driver and popped by a negedge monitor.
module tb_fmm_row_nnz_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ap_start;
  logic [16:0] row_base;
  logic [31:0] ncols;
  logic [16:0] M_e_address0;
  logic        M_e_ce0;
  logic [31:0] M_e_q0;
  logic        ap_done, ap_idle, ap_ready;
  logic [31:0] nnz_count;
  logic [30:0] first_nz_col;
  logic        row_is_zero;
  logic [31:0] pos_count, neg_count;

  fmm_row_nnz_scan dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start),
    .row_base(row_base), .ncols(ncols),
    .M_e_address0(M_e_address0), .M_e_ce0(M_e_ce0), .M_e_q0(M_e_q0),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .nnz_count(nnz_count), .first_nz_col(first_nz_col), .row_is_zero(row_is_zero),
    .pos_count(pos_count), .neg_count(neg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    logic [31:0] nnz;
    logic [30:0] first;
    logic        zero;
    logic [31:0] pos;
    logic [31:0] neg;
    logic        empty;
  } exp_t;

  typedef struct {
    logic [16:0] addr;
    logic        last;
  } addr_t;

  exp_t  exp_q[$];
  addr_t addr_q[$];

  logic [31:0] mem [0:131071];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (M_e_ce0) M_e_q0 <= mem[M_e_address0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (M_e_ce0) begin
        if (addr_q.size() == 0) begin
          chk("unexpected_ce0", 1, 0);
        end else begin
          addr_t a;
          a = addr_q.pop_front();
          chk("address", M_e_address0, a.addr);
          chk("ready_on_read", ap_ready, a.last);
        end
      end
      if (ap_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("nnz_count", nnz_count, e.nnz);
          chk("first_nz_col", first_nz_col, e.first);
          chk("row_is_zero", row_is_zero, e.zero);
          chk("ready_on_done", ap_ready, e.empty);
`ifdef FMM_ROW_SCAN_SIGN_EN
          chk("pos_count", pos_count, e.pos);
          chk("neg_count", neg_count, e.neg);
`else
          chk("pos_count", pos_count, 0);
          chk("neg_count", neg_count, 0);
`endif
        end
      end
      if (ap_ready && !M_e_ce0 && !ap_done) chk("stray_ready", 1, 0);
    end
  end

  task automatic push_addrs(input logic [16:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      addr_t a;
      a.addr = base + 17'(i);
      a.last = (i == n - 1);
      addr_q.push_back(a);
    end
  endtask

  task automatic push_exp(input int n, input logic [31:0] nnz, input logic [30:0] first,
                          input logic [31:0] pos, input logic [31:0] neg);
    exp_t e;
    e.done_cyc = cyc + ((n > 0) ? n + 2 : 1);
    e.nnz      = nnz;
    e.first    = first;
    e.zero     = (nnz == 0);
    e.pos      = pos;
    e.neg      = neg;
    e.empty    = (n <= 0);
    exp_q.push_back(e);
  endtask

  task automatic start_scan(input logic [16:0] base, input int n, input logic [31:0] nnz,
                            input logic [30:0] first, input logic [31:0] pos, input logic [31:0] neg);
    row_base = base;
    ncols    = n;
    ap_start = 1'b1;
    push_addrs(base, n);
    push_exp(n, nnz, first, pos, neg);
    @(negedge clk); #2;
    ap_start = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && addr_q.size() == 0) break;
      @(negedge clk); #2;
    end
    if (i == 200) chk("drain_timeout", 1, 0);
    @(negedge clk); #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    rst_n = 1'b0; ap_start = 1'b0; row_base = '0; ncols = '0;
    for (int i = 0; i < 131072; i++) mem[i] = 32'd0;
    mem[101] = 32'd5;
    mem[103] = 32'hFFFF_FFFD;
    mem[17'h1FFFE] = 32'd7; mem[17'h1FFFF] = 32'd7; mem[0] = 32'd7;
    mem[203] = 32'h8000_0000; mem[204] = 32'd1;
    mem[308] = 32'd9;
    mem[501] = 32'd4;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ce0", M_e_ce0, 0);
    chk("rst_first", first_nz_col, 31'h7FFF_FFFF);
    chk("rst_zero", row_is_zero, 1);
    chk("rst_nnz", nnz_count, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
    chk("idle_after_reset", ap_idle, 1);

    start_scan(17'd100, 4, 2, 31'd1, 1, 1);
    wait_drain();
    repeat (3) @(negedge clk);
    #2;
    chk("hold_nnz", nnz_count, 2);
    chk("hold_first", first_nz_col, 31'd1);
    chk("hold_zero", row_is_zero, 0);

    start_scan(17'd100, 0, 0, 31'h7FFF_FFFF, 0, 0);
    wait_drain();
    start_scan(17'd100, -1, 0, 31'h7FFF_FFFF, 0, 0);
    wait_drain();

    start_scan(17'h1FFFE, 3, 3, 31'd0, 3, 0);
    wait_drain();

    start_scan(17'd400, 2, 0, 31'h7FFF_FFFF, 0, 0);
    wait_drain();

    // start held high, inputs changed mid-scan; a second scan begins only back in IDLE
    x = cyc;
    row_base = 17'd200; ncols = 5; ap_start = 1'b1;
    push_addrs(17'd200, 5);
    push_exp(5, 2, 31'd3, 1, 1);
    @(negedge clk); #2;
    row_base = 17'd300; ncols = 9;
    while (cyc < x + 8) begin @(negedge clk); #2; end
    push_addrs(17'd300, 9);
    push_exp(9, 1, 31'd8, 1, 0);
    @(negedge clk); #2;
    ap_start = 1'b0;
    wait_drain();

    // reset in cycle 2 of an 8-column scan
    row_base = 17'd500; ncols = 8; ap_start = 1'b1;
    push_addrs(17'd500, 8);
    @(negedge clk); #2;
    ap_start = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    addr_q.delete();
    chk("mid_rst_ce0", M_e_ce0, 0);
    chk("mid_rst_addr", M_e_address0, 0);
    chk("mid_rst_done", ap_done, 0);
    chk("mid_rst_ready", ap_ready, 0);
    chk("mid_rst_nnz", nnz_count, 0);
    chk("mid_rst_zero", row_is_zero, 1);
    chk("mid_rst_first", first_nz_col, 31'h7FFF_FFFF);
    chk("mid_rst_pos", pos_count, 0);
    chk("mid_rst_neg", neg_count, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("idle_after_mid_rst", ap_idle, 1);
    repeat (15) @(negedge clk);
    #2;
    chk("no_done_after_rst", exp_q.size(), 0);

    start_scan(17'd100, 4, 2, 31'd1, 1, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
